// File: rtl/duc_fs4_tx.sv
// Transmit digital upconverter: 2-entry I/Q input FIFO, linear interpolation by R,
// and an exact FS/4 real mixer that drives a registered DAC sample stream.
module duc_fs4_tx #(
  parameter int unsigned WI = 16,
  parameter int unsigned R  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [WI-1:0] i_in,
  input  logic signed [WI-1:0] q_in,
  input  logic                 iq_in_val,
  output logic                 iq_in_rdy,
  output logic signed [WI-1:0] dac_out,
  output logic                 dac_val,
  output logic                 underrun,
  output logic [15:0]          underrun_cnt
);
  localparam int unsigned L  = $clog2(R);
  localparam int unsigned DW = WI + 1;
  localparam int unsigned AW = WI + L + 1;
  localparam int unsigned CW = 16;
  localparam logic [L-1:0] M_LAST = L'(R - 1);
  localparam logic signed [WI-1:0] S_MIN = {1'b1, {(WI-1){1'b0}}};
  localparam logic signed [WI-1:0] S_MAX = {1'b0, {(WI-1){1'b1}}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_nxt;

  logic signed [WI-1:0] fifo_i [2];
  logic signed [WI-1:0] fifo_q [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count, count_nxt;
  logic                 push, pop, fifo_empty;
  logic                 start, stop, fetch;

  logic signed [WI-1:0] cur_i, cur_q, prev_i, prev_q;
  logic signed [AW-1:0] acc_i, acc_q;
  logic signed [DW-1:0] delta_i, delta_q;
  logic signed [WI-1:0] v_i, v_q, neg_i, neg_q, mix;
  logic [L-1:0]         m;
  logic [1:0]           p;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Run control: start pops the first sample, fetch marks the end of each R-cycle period.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    fetch     = 1'b0;
    case (state)
      IDLE: begin
        if (en && !fifo_empty) begin
          state_nxt = RUN;
          start     = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
          stop      = 1'b1;
        end else if (m == M_LAST) begin
          fetch = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_empty = (count == 2'd0);
  assign push       = iq_in_val && iq_in_rdy;
  assign pop        = start || (fetch && !fifo_empty);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // Ready follows the next count, so a full FIFO can never accept a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_i    <= '{default: '0};
      fifo_q    <= '{default: '0};
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      iq_in_rdy <= 1'b0;
    end else begin
      if (push) begin
        fifo_i[wr_ptr] <= i_in;
        fifo_q[wr_ptr] <= q_in;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count     <= count_nxt;
      iq_in_rdy <= (count_nxt < 2'd2);
    end
  end

  // acc holds v scaled by R; floor shift recovers the interpolated sample.
  always_comb begin
    delta_i = DW'(cur_i) - DW'(prev_i);
    delta_q = DW'(cur_q) - DW'(prev_q);
    v_i     = WI'(acc_i >>> L);
    v_q     = WI'(acc_q >>> L);
    neg_i   = (v_i == S_MIN) ? S_MAX : -v_i;
    neg_q   = (v_q == S_MIN) ? S_MAX : -v_q;
    case (p)
      2'd0:    mix = v_i;
      2'd1:    mix = neg_q;
      2'd2:    mix = neg_i;
      default: mix = v_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      cur_i  <= '0;
      cur_q  <= '0;
      prev_i <= '0;
      prev_q <= '0;
      acc_i  <= '0;
      acc_q  <= '0;
      m      <= '0;
      p      <= 2'd0;
    end else if (start) begin
      cur_i  <= fifo_i[rd_ptr];
      cur_q  <= fifo_q[rd_ptr];
      prev_i <= '0;
      prev_q <= '0;
      acc_i  <= '0;
      acc_q  <= '0;
      m      <= '0;
      p      <= 2'd0;
    end else if (state == RUN) begin
      m <= m + L'(1);
      p <= p + 2'd1;
      if (fetch) begin
        acc_i  <= AW'(cur_i) <<< L;
        acc_q  <= AW'(cur_q) <<< L;
        prev_i <= cur_i;
        prev_q <= cur_q;
        cur_i  <= fifo_empty ? '0 : fifo_i[rd_ptr];
        cur_q  <= fifo_empty ? '0 : fifo_q[rd_ptr];
      end else begin
        acc_i <= acc_i + AW'(delta_i);
        acc_q <= acc_q + AW'(delta_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_out      <= '0;
      dac_val      <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      dac_val  <= (state == RUN);
      dac_out  <= (state == RUN) ? mix : '0;
      underrun <= fetch && fifo_empty;
      if (fetch && fifo_empty && (underrun_cnt != '1))
        underrun_cnt <= underrun_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_duc_fs4_tx.sv
// Bench for duc_fs4_tx: cycle model built from the interpolation formula and mixer
// table, compared every cycle, plus hand-computed output sequences per scenario.
module tb_duc_fs4_tx;
  localparam int WI = 16;
  localparam int R  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic signed [WI-1:0] i_in;
  logic signed [WI-1:0] q_in;
  logic                 iq_in_val;
  logic                 iq_in_rdy;
  logic signed [WI-1:0] dac_out;
  logic                 dac_val;
  logic                 underrun;
  logic [15:0]          underrun_cnt;

  duc_fs4_tx #(.WI(WI), .R(R)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .i_in         (i_in),
    .q_in         (q_in),
    .iq_in_val    (iq_in_val),
    .iq_in_rdy    (iq_in_rdy),
    .dac_out      (dac_out),
    .dac_val      (dac_val),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int dac_log[$];
  int acc_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int neg_sat(input int x);
    return (x == -(1 << (WI - 1))) ? ((1 << (WI - 1)) - 1) : -x;
  endfunction

  function automatic int mix_fs4(input int vi, input int vq, input int ph);
    case (ph)
      0:       return vi;
      1:       return neg_sat(vq);
      2:       return neg_sat(vi);
      default: return vq;
    endcase
  endfunction

  // Reference model: sample queue, run flag, period phase, linear-interpolation formula.
  int mq_i[$];
  int mq_q[$];
  bit m_run = 1'b0;
  int m_cur_i = 0, m_cur_q = 0, m_prev_i = 0, m_prev_q = 0, m_m = 0, m_p = 0;
  int exp_out = 0;
  bit exp_val = 1'b0, exp_ur = 1'b0, exp_rdy = 1'b0;
  int exp_cnt = 0;

  always @(posedge clk) begin
    int vi, vq;
    bit push;
    if (rst) begin
      mq_i.delete();
      mq_q.delete();
      m_run = 1'b0;
      m_cur_i = 0; m_cur_q = 0; m_prev_i = 0; m_prev_q = 0; m_m = 0; m_p = 0;
      exp_out = 0; exp_val = 1'b0; exp_ur = 1'b0; exp_rdy = 1'b0; exp_cnt = 0;
    end else begin
      push = iq_in_val && exp_rdy;
      vi = m_prev_i + fdiv((m_cur_i - m_prev_i) * m_m, R);
      vq = m_prev_q + fdiv((m_cur_q - m_prev_q) * m_m, R);
      exp_ur  = 1'b0;
      exp_val = m_run;
      exp_out = m_run ? mix_fs4(vi, vq, m_p) : 0;
      if (!m_run) begin
        if (en && mq_i.size() > 0) begin
          m_run = 1'b1;
          m_cur_i = mq_i.pop_front();
          m_cur_q = mq_q.pop_front();
          m_prev_i = 0; m_prev_q = 0; m_m = 0; m_p = 0;
        end
      end else if (!en) begin
        m_run = 1'b0;
        m_cur_i = 0; m_cur_q = 0; m_prev_i = 0; m_prev_q = 0; m_m = 0; m_p = 0;
      end else begin
        if (m_m == R - 1) begin
          m_prev_i = m_cur_i;
          m_prev_q = m_cur_q;
          if (mq_i.size() > 0) begin
            m_cur_i = mq_i.pop_front();
            m_cur_q = mq_q.pop_front();
          end else begin
            m_cur_i = 0; m_cur_q = 0;
            exp_ur = 1'b1;
            if (exp_cnt < 65535) exp_cnt++;
          end
        end
        m_m = (m_m + 1) % R;
        m_p = (m_p + 1) % 4;
      end
      if (push) begin
        mq_i.push_back(int'(i_in));
        mq_q.push_back(int'(q_in));
      end
      exp_rdy = (mq_i.size() < 2);
    end
  end

  // Per-cycle compare against the model, plus output log and accepted-push count.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("dac_val", int'(dac_val), int'(exp_val));
      chk("dac_out", int'(dac_out), exp_out);
      chk("underrun", int'(underrun), int'(exp_ur));
      chk("underrun_cnt", int'(underrun_cnt), exp_cnt);
      chk("iq_in_rdy", int'(iq_in_rdy), int'(exp_rdy));
      if (dac_val) dac_log.push_back(int'(dac_out));
      if (iq_in_val && iq_in_rdy) acc_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n);
    int g = 0;
    while (dac_log.size() < n && g < 300) begin
      step(1);
      g++;
    end
    if (dac_log.size() < n) begin
      errors++;
      $display("FAIL wait_log timeout act=%0d exp=%0d", dac_log.size(), n);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; iq_in_val = 1'b0; i_in = '0; q_in = '0;
    step(2);
    chk("rdy_in_reset", int'(iq_in_rdy), 0);
    chk("val_in_reset", int'(dac_val), 0);
  endtask

  task automatic check_seq(input string name, input int base, input int lit[8]);
    for (int k = 0; k < 8; k++) begin
      if (base + k < dac_log.size()) chk(name, dac_log[base + k], lit[k]);
      else begin
        errors++;
        $display("FAIL %s missing sample %0d", name, k);
      end
    end
  endtask

  task automatic run_const(input string name, input int vi, input int vq, input int lit[8]);
    int base;
    do_reset();
    i_in = WI'(vi); q_in = WI'(vq); iq_in_val = 1'b1; en = 1'b1; rst = 1'b0;
    base = dac_log.size();
    wait_log(base + 12);
    check_seq(name, base, lit);
    chk({name, "_no_underrun"}, int'(underrun_cnt), 0);
  endtask

  int lit_ci[8]  = '{0, 0, -500, 0, 1000, 0, -1000, 0};
  int lit_cq[8]  = '{0, -250, 0, 750, 0, -1000, 0, 1000};
  int lit_neg[8] = '{0, 0, 16384, 0, -32768, 0, 32767, 0};
  int lit_flr[8] = '{0, 0, 1, 0, -1, 0, 1, 0};
  int lit_ur[8]  = '{0, 0, -400, 0, 800, 0, -400, 0};

  initial begin
    int base, c0, g;
    rst = 1'b1; en = 1'b0; iq_in_val = 1'b0; i_in = '0; q_in = '0;
    step(1);
    chk_on = 1'b1;

    run_const("const_i", 1000, 0, lit_ci);
    run_const("const_q", 0, 1000, lit_cq);
    run_const("neg_sat", -32768, 0, lit_neg);
    run_const("floor", -1, 0, lit_flr);

    // Single sample then starvation.
    do_reset();
    en = 1'b1; i_in = 16'sd800; q_in = '0; rst = 1'b0;
    base = dac_log.size();
    iq_in_val = 1'b1;
    g = 0;
    while (!iq_in_rdy && g < 20) begin step(1); g++; end
    step(1);
    iq_in_val = 1'b0;
    wait_log(base + 4);
    chk("ur_cnt_first", int'(underrun_cnt), 1);
    wait_log(base + 8);
    chk("ur_cnt_second", int'(underrun_cnt), 2);
    wait_log(base + 12);
    check_seq("underrun_ramp", base, lit_ur);
    for (int k = 8; k < 12; k++) chk("underrun_zero", dac_log[base + k], 0);
    chk("ur_cnt_third", int'(underrun_cnt), 3);

    // Mid-run disable, backpressure while idle, restart and throughput.
    do_reset();
    i_in = 16'sd1000; q_in = '0; iq_in_val = 1'b1; en = 1'b1; rst = 1'b0;
    base = dac_log.size();
    wait_log(base + 5);
    en = 1'b0;
    step(1);
    chk("stop_last_val", int'(dac_val), 1);
    chk("stop_last_out", int'(dac_out), -1000);
    step(1);
    chk("stop_val_low", int'(dac_val), 0);
    step(8);
    chk("idle_full_rdy", int'(iq_in_rdy), 0);
    chk("idle_out_zero", int'(dac_out), 0);
    base = dac_log.size();
    en = 1'b1;
    wait_log(base + 8);
    check_seq("restart", base, lit_ci);
    c0 = acc_cnt;
    step(40);
    chk("throughput_pushes", acc_cnt - c0, 40 / R);

    en = 1'b0; iq_in_val = 1'b0;
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
